// File: rtl/falafel_input_fsm.sv
// falafel_input_fsm: request-side duplicate-beat checker.
// Every logical request word arrives twice (primary then copy). The primary
// is buffered; the copy is compared against it and the word is pushed into
// the request FIFO only when both beats agree. A disagreement parks the block
// in ERROR with a sticky flag until software pulses err_clr_i.

package falafel_pkg;
  localparam int DATA_W = 64;
endpackage

module falafel_input_fsm #(
  parameter int DATA_W = falafel_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_val_i,
  output logic              req_rdy_o,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              req_fifo_full_i,
  output logic              req_fifo_write_o,
  output logic [DATA_W-1:0] req_fifo_din_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic [CNT_W-1:0]  word_cnt_o
);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  buffer_reg, buffer_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               rdy_int;
  logic               write_int;
  logic               accept;

  // State and datapath registers; reset discards any half-received pair.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= FIRST;
      buffer_reg <= '0;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      buffer_reg <= buffer_next;
      err_reg    <= err_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next-state logic, handshake readiness and FIFO write decision.
  always_comb begin
    state_next  = state_reg;
    buffer_next = buffer_reg;
    err_next    = err_reg;
    cnt_next    = cnt_reg;
    rdy_int     = 1'b0;
    write_int   = 1'b0;
    accept      = 1'b0;

    case (state_reg)
      FIRST: begin
        // Primary beats never depend on FIFO space; only the copy writes.
        rdy_int = 1'b1;
        accept  = req_val_i;
        if (accept) begin
          buffer_next = req_data_i;
          state_next  = SECOND;
        end
      end
      SECOND: begin
        // Stall the copy while full so a write is never issued into a full FIFO.
        rdy_int = !req_fifo_full_i;
        accept  = req_val_i && rdy_int;
        if (accept) begin
          if (req_data_i == buffer_reg) begin
            write_int  = 1'b1;
            cnt_next   = cnt_reg + 1'b1;
            state_next = FIRST;
          end else begin
            err_next   = 1'b1;
            state_next = ERROR;
          end
        end
      end
      ERROR: begin
        // Blocked until cleared; ready returns only on the cycle after the clear.
        rdy_int = 1'b0;
        if (err_clr_i) begin
          err_next   = 1'b0;
          state_next = FIRST;
        end
      end
      default: begin
        state_next = FIRST;
      end
    endcase
  end

  // Output drive; while rst_i is high the outputs show their reset values at once.
  always_comb begin
    req_rdy_o        = rst_i ? 1'b1 : rdy_int;
    req_fifo_write_o = !rst_i && write_int;
    req_fifo_din_o   = rst_i ? '0 : buffer_reg;
    err_o            = !rst_i && err_reg;
    word_cnt_o       = rst_i ? '0 : cnt_reg;
  end

endmodule

// File: tb/tb_falafel_input_fsm.sv
// Testbench for falafel_input_fsm: directed scenarios plus a randomized run
// checked against a transaction-level model of the duplicate-beat protocol.
`timescale 1ns/1ps

module tb_falafel_input_fsm;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_val_i;
  logic              req_rdy_o;
  logic [DATA_W-1:0] req_data_i;
  logic              req_fifo_full_i;
  logic              req_fifo_write_o;
  logic [DATA_W-1:0] req_fifo_din_o;
  logic              err_o;
  logic              err_clr_i;
  logic [CNT_W-1:0]  word_cnt_o;

  int n_vec = 0;
  int n_bad = 0;

  falafel_input_fsm #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_val_i        (req_val_i),
    .req_rdy_o        (req_rdy_o),
    .req_data_i       (req_data_i),
    .req_fifo_full_i  (req_fifo_full_i),
    .req_fifo_write_o (req_fifo_write_o),
    .req_fifo_din_o   (req_fifo_din_o),
    .err_o            (err_o),
    .err_clr_i        (err_clr_i),
    .word_cnt_o       (word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply inputs just after a rising edge, then wait to the falling edge to observe.
  task automatic drive(input logic val, input logic [DATA_W-1:0] data,
                       input logic full, input logic clr, input logic rst);
    req_val_i       = val;
    req_data_i      = data;
    req_fifo_full_i = full;
    err_clr_i       = clr;
    rst_i           = rst;
    @(negedge clk_i);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (req_rdy_o !== 1'b1 || req_fifo_write_o !== 1'b0 || err_o !== 1'b0 ||
        word_cnt_o !== 4'd0 || req_fifo_din_o !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b wr=%b err=%b cnt=%0d din=%h, required 1 0 0 0 0",
               req_rdy_o, req_fifo_write_o, err_o, word_cnt_o, req_fifo_din_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_rdy_o !== 1'b1 || err_o !== 1'b0 || word_cnt_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_idle: rdy=%b err=%b cnt=%0d, required 1 0 0", req_rdy_o, err_o, word_cnt_o);
    end
    tick();
  endtask

  task automatic test_basic_pair();
    do_reset();
    drive(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_rdy_o !== 1'b1 || req_fifo_write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_primary: rdy=%b wr=%b, required 1 0", req_rdy_o, req_fifo_write_o);
    end
    tick();
    drive(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_fifo_write_o !== 1'b1 || req_fifo_din_o !== 64'hA5) begin
      n_bad++;
      $display("FAIL basic_copy_write: wr=%b din=%h, required 1 a5", req_fifo_write_o, req_fifo_din_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (word_cnt_o !== 4'd1 || err_o !== 1'b0 || req_fifo_write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_after: cnt=%0d err=%b wr=%b, required 1 0 0", word_cnt_o, err_o, req_fifo_write_o);
    end
    tick();
  endtask

  task automatic test_gapped_full();
    int writes;
    do_reset();
    writes = 0;
    drive(1'b1, 64'h1234, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (req_fifo_write_o !== 1'b0 || req_rdy_o !== 1'b1) begin
        n_bad++;
        $display("FAIL gap_idle: wr=%b rdy=%b, required 0 1", req_fifo_write_o, req_rdy_o);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h1234, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (req_rdy_o !== 1'b0 || req_fifo_write_o !== 1'b0) begin
        n_bad++;
        $display("FAIL full_stall: rdy=%b wr=%b, required 0 0", req_rdy_o, req_fifo_write_o);
      end
      tick();
    end
    drive(1'b1, 64'h1234, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_fifo_write_o !== 1'b1 || req_fifo_din_o !== 64'h1234) begin
      n_bad++;
      $display("FAIL full_release: wr=%b din=%h, required 1 1234", req_fifo_write_o, req_fifo_din_o);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (req_fifo_write_o === 1'b1) writes++;
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (writes != 0 || word_cnt_o !== 4'd1) begin
      n_bad++;
      $display("FAIL gapped_single_write: extra_writes=%0d cnt=%0d, required 0 1", writes, word_cnt_o);
    end
    tick();
  endtask

  task automatic test_mismatch_recovery();
    do_reset();
    drive(1'b1, 64'h10, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_fifo_write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mismatch_nowrite: wr=%b, required 0", req_fifo_write_o);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (err_o !== 1'b1 || req_rdy_o !== 1'b0 || req_fifo_write_o !== 1'b0 || word_cnt_o !== 4'd0) begin
        n_bad++;
        $display("FAIL error_hold[%0d]: err=%b rdy=%b wr=%b cnt=%0d, required 1 0 0 0",
                 i, err_o, req_rdy_o, req_fifo_write_o, word_cnt_o);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (req_rdy_o !== 1'b0 || err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_cycle: rdy=%b err=%b, required 0 1", req_rdy_o, err_o);
    end
    tick();
    drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_rdy_o !== 1'b1 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL after_clear: rdy=%b err=%b, required 1 0", req_rdy_o, err_o);
    end
    tick();
    drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_fifo_write_o !== 1'b1 || req_fifo_din_o !== 64'h22) begin
      n_bad++;
      $display("FAIL recover_write: wr=%b din=%h, required 1 22", req_fifo_write_o, req_fifo_din_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (word_cnt_o !== 4'd1) begin
      n_bad++;
      $display("FAIL recover_cnt: cnt=%0d, required 1", word_cnt_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] expq[$];
    do_reset();
    for (int i = 0; i < 8; i++) expq.push_back(64'(i));
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 64'(c / 2), 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ((c % 2) == 1) begin
        if (req_fifo_write_o !== 1'b1 || expq.size() == 0 || req_fifo_din_o !== expq[0]) begin
          n_bad++;
          $display("FAIL b2b_write[%0d]: wr=%b din=%h, required 1 %h", c, req_fifo_write_o,
                   req_fifo_din_o, 64'(c / 2));
        end
        if (expq.size() != 0) void'(expq.pop_front());
      end else if (req_fifo_write_o !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_nowrite[%0d]: wr=%b, required 0", c, req_fifo_write_o);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (word_cnt_o !== 4'd8) begin
      n_bad++;
      $display("FAIL b2b_cnt: cnt=%0d, required 8", word_cnt_o);
    end
    tick();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int p = 0; p < 17; p++) begin
      drive(1'b1, 64'(p * 3 + 7), 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'(p * 3 + 7), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (word_cnt_o !== 4'd1) begin
      n_bad++;
      $display("FAIL counter_wrap: cnt=%0d, required 1", word_cnt_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_pair();
    int writes;
    do_reset();
    writes = 0;
    drive(1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (req_fifo_write_o !== 1'b0 || req_fifo_din_o !== 64'd0 || req_rdy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_pair_outputs: wr=%b din=%h rdy=%b, required 0 0 1",
               req_fifo_write_o, req_fifo_din_o, req_rdy_o);
    end
    tick();
    drive(1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b0);
    if (req_fifo_write_o === 1'b1) writes++;
    tick();
    drive(1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (req_fifo_write_o !== 1'b1 || writes != 0) begin
      n_bad++;
      $display("FAIL reset_mid_pair_write: wr_second=%b early_writes=%0d, required 1 0",
               req_fifo_write_o, writes);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (err_o !== 1'b0 || word_cnt_o !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_mid_pair_after: err=%b cnt=%0d, required 0 1", err_o, word_cnt_o);
    end
    tick();
    // Reset taken while in error and while clear is asserted.
    drive(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (err_o !== 1'b0 || req_rdy_o !== 1'b1 || word_cnt_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_in_error: err=%b rdy=%b cnt=%0d, required 0 1 0", err_o, req_rdy_o, word_cnt_o);
    end
    tick();
  endtask

  // Randomized run against a protocol-level model: "is a primary word held?",
  // "is the link blocked by an error?", and a word count modulo 2^CNT_W.
  task automatic test_random();
    bit                have_primary = 0;
    bit                blocked      = 0;
    logic [DATA_W-1:0] primary_word = '0;
    int                words        = 0;
    logic              val, full, clr, rst;
    logic [DATA_W-1:0] data;
    logic              e_rdy, e_wr, e_err;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      val  = ($urandom_range(0, 9) < 7);
      full = ($urandom_range(0, 9) < 3);
      clr  = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      if (have_primary && $urandom_range(0, 9) != 0) data = primary_word;
      else data = {$urandom(), $urandom()};
      drive(val, data, full, clr, rst);

      e_rdy = rst ? 1'b1 : (blocked ? 1'b0 : (have_primary ? !full : 1'b1));
      e_wr  = !rst && !blocked && have_primary && val && !full && (data == primary_word);
      e_err = !rst && blocked;
      n_vec++;
      if (req_rdy_o !== e_rdy || req_fifo_write_o !== e_wr || err_o !== e_err ||
          word_cnt_o !== (rst ? 4'd0 : 4'(words)) ||
          (e_wr && req_fifo_din_o !== primary_word) || (rst && req_fifo_din_o !== 64'd0)) begin
        n_bad++;
        $display("FAIL random[%0d]: rdy=%b/%b wr=%b/%b err=%b/%b cnt=%0d/%0d din=%h/%h (got/required)",
                 c, req_rdy_o, e_rdy, req_fifo_write_o, e_wr, err_o, e_err,
                 word_cnt_o, rst ? 0 : words % 16, req_fifo_din_o, rst ? 64'd0 : primary_word);
      end

      if (rst) begin
        have_primary = 0; blocked = 0; words = 0; primary_word = '0;
      end else if (blocked) begin
        if (clr) blocked = 0;
      end else if (val && e_rdy) begin
        if (!have_primary) begin
          have_primary = 1;
          primary_word = data;
        end else begin
          have_primary = 0;
          if (data == primary_word) words = (words + 1) % 16;
          else blocked = 1;
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1; req_val_i = 1'b0; req_data_i = '0; req_fifo_full_i = 1'b0; err_clr_i = 1'b0;
    tick();
    test_reset();
    test_basic_pair();
    test_gapped_full();
    test_mismatch_recovery();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid_pair();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
